// File: rtl/hiscore_upload_server_pkg.sv
// Shared types and constants for the ioctl upload responder.
package ioctl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PAUSE,
        READY,
        FETCH,
        DONE
    } upl_state_t;

    localparam int         IOCTL_ADDR_W = 25;
    localparam logic [7:0] UPL_FILL     = 8'hFF;

endpackage

// File: rtl/hiscore_upload_server_if.sv
// hps_io ioctl upload bus: master is the HPS side, slave is the core responder.
interface hiscore_upload_server_if;
    import ioctl_pkg::*;

    logic                    ioctl_upload;
    logic                    ioctl_rd;
    logic [IOCTL_ADDR_W-1:0] ioctl_addr;
    logic [7:0]              ioctl_din;
    logic                    ioctl_wait;

    modport master (
        output ioctl_upload,
        output ioctl_rd,
        output ioctl_addr,
        input  ioctl_din,
        input  ioctl_wait
    );

    modport slave (
        input  ioctl_upload,
        input  ioctl_rd,
        input  ioctl_addr,
        output ioctl_din,
        output ioctl_wait
    );

endinterface

// File: rtl/hiscore_upload_server_rd_latency_pipe.sv
// Valid shift register matching the RAM read latency; its output marks when ram_q is good.
module rd_latency_pipe #(
    parameter int LAT = 1
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic i_vld,
    input  logic i_flush,
    output logic o_vld
);

    logic [LAT-1:0] r_vld;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_vld <= '0;
        end else if (i_flush) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= i_vld;
            for (int k = 1; k < LAT; k++) begin
                r_vld[k] <= r_vld[k-1];
            end
        end
    end

    assign o_vld = r_vld[LAT-1];

endmodule

// File: rtl/hiscore_upload_server.sv
// Serves HPS upload byte reads from a core-side RAM while holding the game CPU paused.
//
//  state | meaning
//  IDLE  | no transfer, waiting for ioctl_upload rising edge
//  PAUSE | pause_req raised, waiting for pause_ack or timeout
//  READY | accepting reads (live strobe or latched pending one)
//  FETCH | RAM read in flight, ioctl_wait held high
//  DONE  | transfer ended, one-cycle cleanup before IDLE
module hiscore_upload_server
    import ioctl_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int RD_LAT      = 1,
    parameter int ACK_TIMEOUT = 50000
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    hiscore_upload_server_if.slave ioctl,
    output logic                 o_pause_req,
    input  logic                 i_pause_ack,
    output logic [ADDR_W-1:0]    o_ram_addr,
    output logic                 o_ram_rd,
    input  logic [7:0]           i_ram_q,
    output logic                 o_busy,
    output logic                 o_err
);

    localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(ACK_TIMEOUT - 1);

    upl_state_t              r_state;
    logic                    r_upload_d;
    logic                    r_rise_hold;
    logic [TMR_W-1:0]        r_timer;
    logic                    r_pend;
    logic [IOCTL_ADDR_W-1:0] r_pend_addr;
    logic [7:0]              r_din;
    logic                    r_wait;
    logic                    r_pause_req;
    logic [ADDR_W-1:0]       r_ram_addr;
    logic                    r_err;

    logic              w_upload;
    logic              w_rd;
    logic              w_rise;
    logic              w_live_in;
    logic              w_pend_in;
    logic              w_serve;
    logic              w_serve_in;
    logic [ADDR_W-1:0] w_serve_lo;
    logic              w_fetch_go;
    logic              w_to_done;
    logic              w_cap;

    assign w_upload   = ioctl.ioctl_upload;
    assign w_rd       = ioctl.ioctl_rd & w_upload;
    assign w_rise     = w_upload & ~r_upload_d;
    assign w_live_in  = ~|ioctl.ioctl_addr[IOCTL_ADDR_W-1:ADDR_W];
    assign w_pend_in  = ~|r_pend_addr[IOCTL_ADDR_W-1:ADDR_W];

    // A latched read always takes priority over a live strobe in READY.
    assign w_serve    = (r_state == READY) && w_upload && (r_pend || w_rd);
    assign w_serve_in = r_pend ? w_pend_in : w_live_in;
    assign w_serve_lo = r_pend ? r_pend_addr[ADDR_W-1:0] : ioctl.ioctl_addr[ADDR_W-1:0];
    assign w_fetch_go = w_serve && w_serve_in;
    assign w_to_done  = (r_state != IDLE) && (r_state != DONE) && !w_upload;

    rd_latency_pipe #(.LAT(RD_LAT)) u_pipe (
        .clk_sys (clk_sys),
        .reset   (reset),
        .i_vld   (w_fetch_go),
        .i_flush (w_to_done),
        .o_vld   (w_cap)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_upload_d  <= 1'b0;
            r_rise_hold <= 1'b0;
            r_timer     <= '0;
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
            r_din       <= 8'h00;
            r_wait      <= 1'b0;
            r_pause_req <= 1'b0;
            r_ram_addr  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_upload_d  <= w_upload;
            r_rise_hold <= 1'b0;
            if (w_to_done) begin
                r_state     <= DONE;
                r_pause_req <= 1'b0;
                r_wait      <= 1'b0;
                r_pend      <= 1'b0;
            end else begin
                if ((r_state == PAUSE || r_state == FETCH) && w_rd) begin
                    if (r_pend) begin
                        r_err <= 1'b1;
                    end else begin
                        r_pend      <= 1'b1;
                        r_pend_addr <= ioctl.ioctl_addr;
                    end
                end
                case (r_state)
                    IDLE: begin
                        if (w_rise || (r_rise_hold && w_upload)) begin
                            r_state     <= PAUSE;
                            r_pause_req <= 1'b1;
                            r_wait      <= 1'b1;
                            r_err       <= 1'b0;
                            r_timer     <= TMR_LOAD;
                            r_pend      <= 1'b0;
                        end
                    end
                    PAUSE: begin
                        if (i_pause_ack) begin
                            r_state <= READY;
                            r_wait  <= 1'b0;
                        end else if (r_timer == '0) begin
                            r_state <= READY;
                            r_wait  <= 1'b0;
                            r_err   <= 1'b1;
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                    end
                    READY: begin
                        if (w_fetch_go) begin
                            r_state    <= FETCH;
                            r_wait     <= 1'b1;
                            r_ram_addr <= w_serve_lo;
                        end else if (w_serve) begin
                            r_din <= UPL_FILL;
                        end
                        // Serving the pending slot frees it for a strobe arriving this same cycle.
                        if (r_pend) begin
                            r_pend      <= w_rd;
                            r_pend_addr <= ioctl.ioctl_addr;
                        end
                    end
                    FETCH: begin
                        if (w_cap) begin
                            r_din   <= i_ram_q;
                            r_wait  <= 1'b0;
                            r_state <= READY;
                        end
                    end
                    DONE: begin
                        r_state     <= IDLE;
                        r_rise_hold <= w_rise;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign ioctl.ioctl_din  = r_din;
    assign ioctl.ioctl_wait = r_wait | w_fetch_go;
    assign o_pause_req      = r_pause_req;
    assign o_ram_rd         = w_fetch_go;
    assign o_ram_addr       = w_fetch_go ? w_serve_lo : r_ram_addr;
    assign o_busy           = (r_state != IDLE);
    assign o_err            = r_err;

endmodule

// File: tb/tb_hiscore_upload_server.sv
// Scoreboard bench for hiscore_upload_server: random HPS reads vs. a RAM-content model, plus directed corner cases.
module tb_hiscore_upload_server;

    localparam int ADDR_W      = 10;
    localparam int RD_LAT      = 2;
    localparam int ACK_TIMEOUT = 50;
    localparam int DEPTH       = 1 << ADDR_W;

    typedef struct packed {
        logic [7:0] din;
        logic       fetch;
    } exp_t;

    logic              clk_sys = 1'b0;
    logic              reset;
    logic              pause_req;
    logic              pause_ack;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rd;
    logic [7:0]        ram_q;
    logic              busy;
    logic              err;

    hiscore_upload_server_if bus();

    hiscore_upload_server #(
        .ADDR_W      (ADDR_W),
        .RD_LAT      (RD_LAT),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ioctl       (bus),
        .o_pause_req (pause_req),
        .i_pause_ack (pause_ack),
        .o_ram_addr  (ram_addr),
        .o_ram_rd    (ram_rd),
        .i_ram_q     (ram_q),
        .o_busy      (busy),
        .o_err       (err)
    );

    always #5 clk_sys = ~clk_sys;

    // RAM model: data appears exactly RD_LAT cycles after the read strobe, sentinel otherwise.
    logic [7:0] mem [DEPTH];
    logic [7:0] ram_pipe [RD_LAT];

    initial begin
        for (int k = 0; k < RD_LAT; k++) ram_pipe[k] = 8'hEE;
    end

    always @(posedge clk_sys) begin
        ram_pipe[0] <= ram_rd ? mem[ram_addr] : 8'hEE;
        for (int k = 1; k < RD_LAT; k++) ram_pipe[k] <= ram_pipe[k-1];
    end
    assign ram_q = ram_pipe[RD_LAT-1];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a read result.
    exp_t exp_q[$];
    bit   mon_en    = 1'b0;
    bit   mon_imm   = 1'b0;
    bit   mon_fetch = 1'b0;
    int   mon_age   = 0;
    int   ram_rd_cnt = 0;

    task automatic mon_pop();
        exp_t e;
        e = exp_q.pop_front();
        check("read_data", bus.ioctl_din, e.din);
    endtask

    always @(negedge clk_sys) begin
        if (ram_rd) ram_rd_cnt++;
        if (mon_imm) begin
            mon_imm = 1'b0;
            mon_pop();
        end else if (mon_fetch) begin
            mon_age++;
            if (!bus.ioctl_wait) begin
                mon_fetch = 1'b0;
                check("fetch_latency", mon_age, RD_LAT + 1);
                mon_pop();
            end else if (mon_age > 20) begin
                mon_fetch = 1'b0;
                check("fetch_latency", mon_age, RD_LAT + 1);
                void'(exp_q.pop_front());
            end
        end
        if (mon_en && bus.ioctl_rd && bus.ioctl_upload) begin
            check("strobe_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                check("wait_at_strobe", bus.ioctl_wait, exp_q[0].fetch);
                if (bus.ioctl_wait) begin
                    mon_fetch = 1'b1;
                    mon_age   = 0;
                end else begin
                    mon_imm = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    int exp_fetches = 0;

    task automatic hps_read(input logic [24:0] a);
        exp_t e;
        int   n;
        n = 0;
        while (bus.ioctl_wait && n < 100) begin tick(); n++; end
        e.fetch = (a < DEPTH);
        e.din   = e.fetch ? mem[a[ADDR_W-1:0]] : 8'hFF;
        if (e.fetch) exp_fetches++;
        exp_q.push_back(e);
        bus.ioctl_rd   = 1'b1;
        bus.ioctl_addr = a;
        tick();
        bus.ioctl_rd = 1'b0;
        n = 0;
        while ((exp_q.size() != 0 || mon_fetch || mon_imm) && n < 100) begin tick(); n++; end
        check("read_completes", n < 100, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int              n;
        int              base;
        logic [24:0]     a;
        logic [ADDR_W-1:0] a1;

        reset          = 1'b1;
        pause_ack      = 1'b0;
        bus.ioctl_upload = 1'b0;
        bus.ioctl_rd   = 1'b0;
        bus.ioctl_addr = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom_range(0, 255));
        mem[16] = 8'hA5;
        repeat (3) @(posedge clk_sys);
        #1;
        check("rst_din", bus.ioctl_din, 8'h00);
        check("rst_wait", bus.ioctl_wait, 0);
        check("rst_pause_req", pause_req, 0);
        check("rst_ram_rd", ram_rd, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        reset = 1'b0;
        tick();

        // Upload start, ack after 5 cycles
        bus.ioctl_upload = 1'b1;
        tick();
        check("start_pause_req", pause_req, 1);
        check("start_wait", bus.ioctl_wait, 1);
        check("start_busy", busy, 1);
        repeat (4) tick();
        check("wait_before_ack", bus.ioctl_wait, 1);
        pause_ack = 1'b1;
        tick();
        check("wait_after_ack", bus.ioctl_wait, 0);
        check("err_after_ack", err, 0);
        check("pause_req_ready", pause_req, 1);

        // Scoreboarded reads: known value, out-of-range, edges, then random traffic
        mon_en = 1'b1;
        base = ram_rd_cnt;
        exp_fetches = 0;
        hps_read(25'h010);
        check("a5_din", bus.ioctl_din, 8'hA5);
        hps_read(25'h400);
        check("oor_din", bus.ioctl_din, 8'hFF);
        hps_read(25'h3FF);
        hps_read(25'h1FFFFFF);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) != 0) a = 25'($urandom_range(0, DEPTH - 1));
            else                           a = 25'($urandom_range(DEPTH, 32'h1FFFFFF));
            if (a < DEPTH && $urandom_range(0, 1) == 1) mem[a[ADDR_W-1:0]] = 8'($urandom_range(0, 255));
            hps_read(a);
        end
        check("ram_rd_count", ram_rd_cnt - base, exp_fetches);
        check("no_err_clean_traffic", err, 0);
        mon_en = 1'b0;

        // Two strobes during FETCH: first queued, second dropped
        a1 = ADDR_W'($urandom_range(0, DEPTH - 5));
        mem[a1] = 8'h11; mem[a1 + 1] = 8'h22; mem[a1 + 2] = 8'h33; mem[a1 + 3] = 8'h44;
        base = ram_rd_cnt;
        bus.ioctl_rd = 1'b1;
        bus.ioctl_addr = 25'(a1);
        tick();
        bus.ioctl_addr = 25'(a1 + 1);
        tick();
        bus.ioctl_addr = 25'(a1 + 2);
        tick();
        bus.ioctl_rd = 1'b0;
        check("ovr_first_data", bus.ioctl_din, 8'h11);
        check("ovr_err", err, 1);
        check("ovr_pending_addr", ram_addr, a1 + 1);
        check("ovr_pending_wait", bus.ioctl_wait, 1);
        n = 0;
        while (bus.ioctl_wait && n < 20) begin tick(); n++; end
        check("ovr_pending_latency", n, RD_LAT + 1);
        check("ovr_second_data", bus.ioctl_din, 8'h22);
        repeat (4) tick();
        check("ovr_dropped_no_fetch", ram_rd_cnt - base, 2);
        check("ovr_din_hold", bus.ioctl_din, 8'h22);

        // Upload falls mid-FETCH
        bus.ioctl_rd = 1'b1;
        bus.ioctl_addr = 25'(a1 + 3);
        tick();
        bus.ioctl_rd = 1'b0;
        bus.ioctl_upload = 1'b0;
        pause_ack = 1'b0;
        tick();
        check("abort_pause_req", pause_req, 0);
        check("abort_wait", bus.ioctl_wait, 0);
        check("abort_done_busy", busy, 1);
        tick();
        check("abort_idle", busy, 0);
        repeat (3) tick();
        check("abort_din_hold", bus.ioctl_din, 8'h22);

        // Ack never comes: timeout after ACK_TIMEOUT cycles
        bus.ioctl_upload = 1'b1;
        tick();
        n = 0;
        while (bus.ioctl_wait && n < 200) begin n++; tick(); end
        check("timeout_cycles", n, ACK_TIMEOUT);
        check("timeout_err", err, 1);
        check("timeout_pause_req", pause_req, 1);
        check("timeout_busy", busy, 1);

        // Upload re-rises while in DONE; edge must be kept, err cleared
        bus.ioctl_upload = 1'b0;
        tick();
        bus.ioctl_upload = 1'b1;
        tick();
        tick();
        check("rerise_pause_req", pause_req, 1);
        check("rerise_wait", bus.ioctl_wait, 1);
        check("rerise_err_clear", err, 0);
        pause_ack = 1'b1;
        tick();
        check("rerise_ready", bus.ioctl_wait, 0);
        pause_ack = 1'b0;
        tick();
        check("ack_drop_ignored", pause_req, 1);
        mon_en = 1'b1;
        hps_read(25'($urandom_range(0, DEPTH - 1)));
        hps_read(25'($urandom_range(DEPTH, 32'hFFFF)));
        mon_en = 1'b0;

        // Reset pulse mid-FETCH with err set
        bus.ioctl_rd = 1'b1;
        bus.ioctl_addr = 25'(a1);
        tick();
        bus.ioctl_addr = 25'(a1 + 1);
        tick();
        bus.ioctl_addr = 25'(a1 + 2);
        tick();
        bus.ioctl_rd = 1'b0;
        check("pre_reset_err", err, 1);
        tick();
        reset = 1'b1;
        #1;
        check("reset_pause_req", pause_req, 0);
        check("reset_busy", busy, 0);
        check("reset_err", err, 0);
        check("reset_wait", bus.ioctl_wait, 0);
        check("reset_din", bus.ioctl_din, 8'h00);
        bus.ioctl_upload = 1'b0;
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check("post_reset_idle", busy, 0);
        check("post_reset_ram_rd", ram_rd, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
